// File: rtl/wb_arbiter.sv
// Register-file write-back arbiter: merges W-stage writes and queued MDU results onto one GRF write port.
// Latency: pipe request 1 cycle to grf_*; MDU result at least 2 cycles (always passes through the FIFO).
// Backpressure: both readies drop together when the MDU FIFO is full or reset is asserted; never depend on valids.
//
// Ports:
//   clk_i, reset_i                     clock, synchronous active-high reset
//   pipe_{valid,rd,data,pc}_i          W-stage write request; pipe_ready_o accepts it
//   mdu_{valid,rd,data,pc}_i           MDU result request;   mdu_ready_o accepts it into the FIFO
//   grf_{we,rd,data,pc}_o              registered GRF write port
//   mdu_count_o                        MDU FIFO occupancy

// Small circular FIFO used for queued MDU results.
// Latency: written entry is visible at the head one cycle after the push edge.
// Backpressure: none internally; the caller only pushes when not full and only pops when not empty.
module wb_arbiter_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2,
    parameter int CW    = 2
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          push_i,
    input  logic [W-1:0]  wdat_i,
    input  logic          pop_i,
    output logic [W-1:0]  rdat_o,
    output logic [CW-1:0] count_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (pop_i) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        if (push_i && !pop_i) begin
            count_d = count_q + CW'(1);
        end else if (pop_i && !push_i) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= wdat_i;
        end
    end

    assign rdat_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
endmodule

// Top-level arbiter. Priority: full FIFO head, then pipe, then non-empty FIFO head.
// Latency: winner registered onto grf_* on the edge it wins.
// Backpressure: pipe_ready_o/mdu_ready_o = !reset_i && FIFO not full.
module wb_arbiter #(
    parameter int DEPTH = 2,
    parameter int CW    = 2
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          pipe_valid_i,
    input  logic [4:0]    pipe_rd_i,
    input  logic [31:0]   pipe_data_i,
    input  logic [31:0]   pipe_pc_i,
    output logic          pipe_ready_o,
    input  logic          mdu_valid_i,
    input  logic [4:0]    mdu_rd_i,
    input  logic [31:0]   mdu_data_i,
    input  logic [31:0]   mdu_pc_i,
    output logic          mdu_ready_o,
    output logic          grf_we_o,
    output logic [4:0]    grf_rd_o,
    output logic [31:0]   grf_data_o,
    output logic [31:0]   grf_pc_o,
    output logic [CW-1:0] mdu_count_o
);
    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
        logic [31:0] pc;
    } entry_t;

    entry_t        mdu_ent;
    entry_t        head;
    logic [CW-1:0] count;
    logic          full;
    logic          rdy;
    logic          pipe_fire;
    logic          mdu_fire;
    logic          fifo_pop;

    logic          we_q,   we_d;
    logic [4:0]    rd_q,   rd_d;
    logic [31:0]   data_q, data_d;
    logic [31:0]   pc_q,   pc_d;

    assign mdu_ent = '{rd: mdu_rd_i, data: mdu_data_i, pc: mdu_pc_i};

    // A full FIFO refuses new entries even while popping, so readiness
    // comes purely from registered occupancy (plus reset).
    assign full      = (count == CW'(DEPTH));
    assign rdy       = !reset_i && !full;
    assign pipe_fire = pipe_valid_i && rdy;
    assign mdu_fire  = mdu_valid_i && rdy;
    // When full the pipe cannot fire, so this also covers the full-head-wins case.
    assign fifo_pop  = !reset_i && (count != '0) && !pipe_fire;

    wb_arbiter_fifo #(
        .W     ($bits(entry_t)),
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .push_i  (mdu_fire),
        .wdat_i  (mdu_ent),
        .pop_i   (fifo_pop),
        .rdat_o  (head),
        .count_o (count)
    );

    always_comb begin
        we_d   = 1'b0;
        rd_d   = rd_q;
        data_d = data_q;
        pc_d   = pc_q;
        if (pipe_fire) begin
            we_d   = 1'b1;
            rd_d   = pipe_rd_i;
            data_d = pipe_data_i;
            pc_d   = pipe_pc_i;
        end else if (fifo_pop) begin
            we_d   = 1'b1;
            rd_d   = head.rd;
            data_d = head.data;
            pc_d   = head.pc;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            we_q   <= 1'b0;
            rd_q   <= '0;
            data_q <= '0;
            pc_q   <= '0;
        end else begin
            we_q   <= we_d;
            rd_q   <= rd_d;
            data_q <= data_d;
            pc_q   <= pc_d;
        end
    end

    assign pipe_ready_o = rdy;
    assign mdu_ready_o  = rdy;
    assign grf_we_o     = we_q;
    assign grf_rd_o     = rd_q;
    assign grf_data_o   = data_q;
    assign grf_pc_o     = pc_q;
    assign mdu_count_o  = count;
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: expected GRF writes queued when driven, checked as they appear.
// Latency: outputs sampled 1ns after each rising edge.
// Backpressure: ready signals checked against hand-derived occupancy.
module tb_wb_arbiter;
    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
        logic [31:0] pc;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        pipe_valid;
    logic [4:0]  pipe_rd;
    logic [31:0] pipe_data;
    logic [31:0] pipe_pc;
    logic        pipe_ready;
    logic        mdu_valid;
    logic [4:0]  mdu_rd;
    logic [31:0] mdu_data;
    logic [31:0] mdu_pc;
    logic        mdu_ready;
    logic        grf_we;
    logic [4:0]  grf_rd;
    logic [31:0] grf_data;
    logic [31:0] grf_pc;
    logic [1:0]  mdu_count;

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];

    wb_arbiter #(.DEPTH(2), .CW(2)) dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .pipe_valid_i (pipe_valid),
        .pipe_rd_i    (pipe_rd),
        .pipe_data_i  (pipe_data),
        .pipe_pc_i    (pipe_pc),
        .pipe_ready_o (pipe_ready),
        .mdu_valid_i  (mdu_valid),
        .mdu_rd_i     (mdu_rd),
        .mdu_data_i   (mdu_data),
        .mdu_pc_i     (mdu_pc),
        .mdu_ready_o  (mdu_ready),
        .grf_we_o     (grf_we),
        .grf_rd_o     (grf_rd),
        .grf_data_o   (grf_data),
        .grf_pc_o     (grf_pc),
        .mdu_count_o  (mdu_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; any GRF write seen must be the next scoreboard entry.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (grf_we === 1'b1) begin
            check("sb_has_entry", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("out_rd",   32'(grf_rd), 32'(e.rd));
                check("out_data", grf_data,    e.data);
                check("out_pc",   grf_pc,      e.pc);
            end
        end
    endtask

    task automatic pipe(input logic v, input logic [4:0] rd, input logic [31:0] d, input logic [31:0] pc);
        pipe_valid = v;
        pipe_rd    = rd;
        pipe_data  = d;
        pipe_pc    = pc;
    endtask

    task automatic mdu(input logic v, input logic [4:0] rd, input logic [31:0] d, input logic [31:0] pc);
        mdu_valid = v;
        mdu_rd    = rd;
        mdu_data  = d;
        mdu_pc    = pc;
    endtask

    function automatic exp_t mk(input logic [4:0] rd, input logic [31:0] d, input logic [31:0] pc);
        exp_t e;
        e.rd   = rd;
        e.data = d;
        e.pc   = pc;
        return e;
    endfunction

    initial begin
        // Reset with both requesters active: nothing may be accepted.
        reset = 1'b1;
        pipe(1'b1, 5'd1, 32'h1111, 32'h100);
        mdu(1'b1, 5'd2, 32'h2222, 32'h200);
        #1;
        check("rst_pipe_ready", 32'(pipe_ready), 32'd0);
        check("rst_mdu_ready",  32'(mdu_ready),  32'd0);
        tick();
        tick();
        check("rst_we",    32'(grf_we),    32'd0);
        check("rst_rd",    32'(grf_rd),    32'd0);
        check("rst_data",  grf_data,       32'd0);
        check("rst_pc",    grf_pc,         32'd0);
        check("rst_count", 32'(mdu_count), 32'd0);
        reset = 1'b0;
        pipe(1'b0, 5'd0, 32'h0, 32'h0);
        mdu(1'b0, 5'd0, 32'h0, 32'h0);
        #1;
        check("idle_pipe_ready", 32'(pipe_ready), 32'd1);
        check("idle_mdu_ready",  32'(mdu_ready),  32'd1);

        // Pipe only, then idle hold, then rd==0 forwarded.
        pipe(1'b1, 5'd5, 32'h1234, 32'h3000);
        sb.push_back(mk(5'd5, 32'h1234, 32'h3000));
        tick();
        check("pipe_we", 32'(grf_we), 32'd1);
        pipe(1'b0, 5'd0, 32'h0, 32'h0);
        tick();
        check("hold_we",   32'(grf_we), 32'd0);
        check("hold_rd",   32'(grf_rd), 32'd5);
        check("hold_data", grf_data,    32'h1234);
        check("hold_pc",   grf_pc,      32'h3000);
        pipe(1'b1, 5'd0, 32'hCAFE, 32'h3004);
        sb.push_back(mk(5'd0, 32'hCAFE, 32'h3004));
        tick();
        check("rd0_we", 32'(grf_we), 32'd1);
        pipe(1'b0, 5'd0, 32'h0, 32'h0);
        tick();

        // MDU only: one cycle in the FIFO before reaching the port.
        mdu(1'b1, 5'd8, 32'hDEAD, 32'h4000);
        tick();
        check("mdu_count1", 32'(mdu_count), 32'd1);
        check("mdu_we0",    32'(grf_we),    32'd0);
        mdu(1'b0, 5'd0, 32'h0, 32'h0);
        sb.push_back(mk(5'd8, 32'hDEAD, 32'h4000));
        tick();
        check("mdu_we1",    32'(grf_we),    32'd1);
        check("mdu_count0", 32'(mdu_count), 32'd0);

        // Contention: pipe wins until full, then head A drains and pipe stalls.
        sb.push_back(mk(5'd10, 32'hA0, 32'h5000));
        sb.push_back(mk(5'd11, 32'hA1, 32'h5004));
        sb.push_back(mk(5'd2,  32'hAAAA, 32'h6000));
        sb.push_back(mk(5'd12, 32'hA2, 32'h5008));
        sb.push_back(mk(5'd3,  32'hBBBB, 32'h6004));
        pipe(1'b1, 5'd10, 32'hA0, 32'h5000);
        mdu(1'b1, 5'd2, 32'hAAAA, 32'h6000);
        tick();
        check("ct_count1", 32'(mdu_count), 32'd1);
        pipe(1'b1, 5'd11, 32'hA1, 32'h5004);
        mdu(1'b1, 5'd3, 32'hBBBB, 32'h6004);
        tick();
        check("ct_count2", 32'(mdu_count), 32'd2);
        pipe(1'b1, 5'd12, 32'hA2, 32'h5008);
        mdu(1'b0, 5'd0, 32'h0, 32'h0);
        #1;
        check("ct_full_pipe_ready", 32'(pipe_ready), 32'd0);
        check("ct_full_mdu_ready",  32'(mdu_ready),  32'd0);
        tick();
        check("ct_drain_count", 32'(mdu_count), 32'd1);
        check("ct_resume_ready", 32'(pipe_ready), 32'd1);
        tick();
        check("ct_pipe_count", 32'(mdu_count), 32'd1);
        pipe(1'b0, 5'd0, 32'h0, 32'h0);
        tick();
        check("ct_empty", 32'(mdu_count), 32'd0);
        tick();
        check("ct_idle_we", 32'(grf_we), 32'd0);

        // Simultaneous push and pop across several edges (exercises pointer wrap).
        for (int k = 0; k < 4; k++) begin
            mdu(1'b1, 5'(20 + k), 32'hC000 + 32'(k), 32'h7000 + 32'(4 * k));
            if (k > 0) sb.push_back(mk(5'(19 + k), 32'hC000 + 32'(k - 1), 32'h7000 + 32'(4 * (k - 1))));
            tick();
            check("pp_count", 32'(mdu_count), 32'd1);
            check("pp_we", 32'(grf_we), (k > 0) ? 32'd1 : 32'd0);
        end
        mdu(1'b0, 5'd0, 32'h0, 32'h0);
        sb.push_back(mk(5'd23, 32'hC003, 32'h700C));
        tick();
        check("pp_drained", 32'(mdu_count), 32'd0);

        // Reset mid-operation with a full FIFO: queued entries must vanish.
        sb.push_back(mk(5'd24, 32'hB0, 32'h8000));
        sb.push_back(mk(5'd25, 32'hB1, 32'h8004));
        pipe(1'b1, 5'd24, 32'hB0, 32'h8000);
        mdu(1'b1, 5'd9, 32'hEEE0, 32'h9000);
        tick();
        pipe(1'b1, 5'd25, 32'hB1, 32'h8004);
        mdu(1'b1, 5'd10, 32'hEEE1, 32'h9004);
        tick();
        check("mr_count2", 32'(mdu_count), 32'd2);
        reset = 1'b1;
        #1;
        check("mr_rst_ready", 32'(pipe_ready), 32'd0);
        tick();
        check("mr_count0", 32'(mdu_count), 32'd0);
        check("mr_we",     32'(grf_we),    32'd0);
        check("mr_rd",     32'(grf_rd),    32'd0);
        check("mr_data",   grf_data,       32'd0);
        reset = 1'b0;
        pipe(1'b0, 5'd0, 32'h0, 32'h0);
        mdu(1'b0, 5'd0, 32'h0, 32'h0);
        repeat (4) tick();
        check("mr_still_empty", 32'(mdu_count), 32'd0);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
